dram_arbiter: RTL and testbench

Shares the single `dram` block (one read port, one write port, 19-bit address, 8-bit data) between `NREQ` requesters, such as the weight loader, the activation fetch and the result writer. Each cycle it grants at most one read and one write, and uses independent round-robin pointers for the two ports. It registers the DRAM command signals and returns read data to the originating requester through a tag pipeline. The block sits directly in front of `dram`, and every DRAM access in the design goes through it.

---
 rtl/dram_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/dram_arbiter.sv | 140 ++++++++++++++
 tb/tb_dram_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared constants and the read-response tag type for the DRAM arbiter.
// The tag index is sized for the largest supported requester count (8).
package dram_arb_pkg;

    localparam int DRAM_ADDR_W = 19;
    localparam int DRAM_DATA_W = 8;
    localparam int DRAM_RD_LAT = 1;
    localparam int NREQ_MAX    = 8;
    localparam int TAG_IDX_W   = $clog2(NREQ_MAX);

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. grant_o is the current winner and does not depend on en_i,
// so the caller can inspect it before deciding to commit it.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    // ptr_q names the highest-priority requester for this cycle.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            for (int i = 0; i < N; i++) begin
                if (grant_o[i]) ptr_d = PW'((i + 1) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one read port and one write port of the DRAM among NREQ requesters,
// registering the DRAM command and routing read data back via a tag pipeline.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int RD_LAT = DRAM_RD_LAT,
    parameter int ADDR_W = DRAM_ADDR_W,
    parameter int DATA_W = DRAM_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   dram_ren,
    output logic                   dram_wen,
    output logic [ADDR_W-1:0]      dram_raddr,
    output logic [ADDR_W-1:0]      dram_waddr,
    output logic [DATA_W-1:0]      dram_wdata,
    input  logic [DATA_W-1:0]      dram_rdata
);

    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [NREQ-1:0] rd_req, wr_req, rd_gnt, wr_gnt, rd_fire;
    logic            hazard;

    assign rd_req = rst ? '0 : (req_valid & ~req_we);
    assign wr_req = rst ? '0 : (req_valid & req_we);

    rr_arbiter #(.N(NREQ)) u_rd_arb (
        .clk(clk), .rst(rst), .req_i(rd_req), .en_i(~hazard), .grant_o(rd_gnt)
    );

    rr_arbiter #(.N(NREQ)) u_wr_arb (
        .clk(clk), .rst(rst), .req_i(wr_req), .en_i(1'b1), .grant_o(wr_gnt)
    );

    logic [ADDR_W-1:0]    rd_addr_sel, wr_addr_sel;
    logic [DATA_W-1:0]    wr_data_sel;
    logic [TAG_IDX_W-1:0] rd_idx;

    always_comb begin
        rd_addr_sel = '0;
        wr_addr_sel = '0;
        wr_data_sel = '0;
        rd_idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rd_gnt[i]) begin
                rd_addr_sel = addr_arr[i];
                rd_idx      = TAG_IDX_W'(i);
            end
            if (wr_gnt[i]) begin
                wr_addr_sel = addr_arr[i];
                wr_data_sel = wdata_arr[i];
            end
        end
    end

    // A same-address read would see stale data, so the write wins and the read retries.
    assign hazard    = (|rd_gnt) && (|wr_gnt) && (rd_addr_sel == wr_addr_sel);
    assign rd_fire   = hazard ? '0 : rd_gnt;
    assign req_ready = rd_fire | wr_gnt;

    logic              ren_q, ren_d, wen_q, wen_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        ren_d   = |rd_fire;
        wen_d   = |wr_gnt;
        raddr_d = ren_d ? rd_addr_sel : raddr_q;
        waddr_d = wen_d ? wr_addr_sel : waddr_q;
        wdata_d = wen_d ? wr_data_sel : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign dram_ren   = ren_q;
    assign dram_wen   = wen_q;
    assign dram_raddr = raddr_q;
    assign dram_waddr = waddr_q;
    assign dram_wdata = wdata_q;

    // Stage 0 mirrors the command register; the last stage lines up with dram_rdata.
    rsp_tag_t tag_q [RD_LAT+1];
    rsp_tag_t tag_d;

    always_comb begin
        tag_d.valid = |rd_fire;
        tag_d.idx   = rd_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= RD_LAT; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int s = 1; s <= RD_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = !rst && tag_q[RD_LAT].valid && (tag_q[RD_LAT].idx == TAG_IDX_W'(i));
        end
    end

    assign rsp_data = dram_rdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a one-cycle-latency DRAM model.
module tb_dram_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 19;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_we, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_data, dram_wdata, dram_rdata;
    logic              dram_ren, dram_wen;
    logic [AW-1:0]     dram_raddr, dram_waddr;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    dram_arbiter #(.NREQ(NREQ), .RD_LAT(1), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .dram_ren(dram_ren), .dram_wen(dram_wen), .dram_raddr(dram_raddr),
        .dram_waddr(dram_waddr), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata)
    );

    always @(posedge clk) begin
        if (dram_wen) mem[dram_waddr] <= dram_wdata;
        if (dram_ren) dram_rdata <= mem[dram_raddr];
    end

    task automatic clear_reqs();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), 8'h00);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (req_ready !== 3'b000 || dram_ren !== 1'b0 || dram_wen !== 1'b0 || rsp_valid !== 3'b000) begin
                bad++;
                $display("FAIL reset c%0d: ready=%b ren=%b wen=%b rsp=%b want 000/0/0/000",
                         c, req_ready, dram_ren, dram_wen, rsp_valid);
            end
            next_cycle();
        end
        rst = 1'b0;
        clear_reqs();
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        do_reset();
        set_req(1, 1'b1, 19'h00010, 8'hA5);
        @(negedge clk);
        total++;
        if (req_ready !== 3'b010) begin bad++; $display("FAIL wr_ready: got %b want 010", req_ready); end
        next_cycle();
        clear_reqs();
        set_req(1, 1'b0, 19'h00010, 8'h00);
        @(negedge clk);
        total++;
        if (dram_wen !== 1'b1 || dram_waddr !== 19'h00010 || dram_wdata !== 8'hA5) begin
            bad++;
            $display("FAIL wr_cmd: wen=%b waddr=%h wdata=%h want 1/00010/a5", dram_wen, dram_waddr, dram_wdata);
        end
        total++;
        if (req_ready !== 3'b010) begin bad++; $display("FAIL rd_ready: got %b want 010", req_ready); end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        total++;
        if (dram_ren !== 1'b1 || dram_raddr !== 19'h00010) begin
            bad++; $display("FAIL rd_cmd: ren=%b raddr=%h want 1/00010", dram_ren, dram_raddr);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (rsp_valid !== 3'b010 || rsp_data !== 8'hA5) begin
            bad++; $display("FAIL rd_rsp: rsp=%b data=%h want 010/a5", rsp_valid, rsp_data);
        end
        next_cycle();
        $display("test_write_read done");
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rdy, exp_rsp;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            clear_reqs();
            if (k < 6) for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(32'h100 + k), 8'h00);
            exp_rdy = (k < 6) ? 3'(1 << (k % 3)) : 3'b000;
            exp_rsp = (k >= 2) ? 3'(1 << ((k - 2) % 3)) : 3'b000;
            @(negedge clk);
            total++;
            if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready k%0d: got %b want %b", k, req_ready, exp_rdy); end
            total++;
            if (rsp_valid !== exp_rsp) begin bad++; $display("FAIL rr_rsp k%0d: got %b want %b", k, rsp_valid, exp_rsp); end
            next_cycle();
        end
        clear_reqs();
        $display("test_round_robin done");
    endtask

    task automatic test_concurrent();
        do_reset();
        set_req(0, 1'b0, 19'h00005, 8'h00);
        set_req(2, 1'b1, 19'h00007, 8'h11);
        @(negedge clk);
        total++;
        if (req_ready !== 3'b101) begin bad++; $display("FAIL conc_ready: got %b want 101", req_ready); end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        total++;
        if (dram_ren !== 1'b1 || dram_wen !== 1'b1 || dram_raddr !== 19'h00005 || dram_waddr !== 19'h00007) begin
            bad++;
            $display("FAIL conc_cmd: ren=%b wen=%b raddr=%h waddr=%h want 1/1/00005/00007",
                     dram_ren, dram_wen, dram_raddr, dram_waddr);
        end
        next_cycle();
        next_cycle();
        $display("test_concurrent done");
    endtask

    task automatic test_hazard();
        do_reset();
        set_req(0, 1'b0, 19'h7FFFF, 8'h00);
        set_req(1, 1'b1, 19'h7FFFF, 8'h3C);
        @(negedge clk);
        total++;
        if (req_ready !== 3'b010) begin bad++; $display("FAIL haz_ready: got %b want 010", req_ready); end
        next_cycle();
        clear_reqs();
        set_req(0, 1'b0, 19'h7FFFF, 8'h00);
        @(negedge clk);
        total++;
        if (req_ready !== 3'b001) begin bad++; $display("FAIL haz_retry: got %b want 001", req_ready); end
        total++;
        if (dram_wen !== 1'b1 || dram_ren !== 1'b0) begin
            bad++; $display("FAIL haz_cmd: wen=%b ren=%b want 1/0", dram_wen, dram_ren);
        end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        total++;
        if (dram_ren !== 1'b1) begin bad++; $display("FAIL haz_ren: got %b want 1", dram_ren); end
        next_cycle();
        @(negedge clk);
        total++;
        if (rsp_valid !== 3'b001 || rsp_data !== 8'h3C) begin
            bad++; $display("FAIL haz_rsp: rsp=%b data=%h want 001/3c", rsp_valid, rsp_data);
        end
        next_cycle();
        $display("test_hazard done");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_req(0, 1'b0, 19'h00020, 8'h00);
        next_cycle();
        clear_reqs();
        set_req(1, 1'b0, 19'h00021, 8'h00);
        next_cycle();
        clear_reqs();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 3'b000) begin bad++; $display("FAIL midrst_rsp c%0d: got %b want 000", c, rsp_valid); end
            next_cycle();
            rst = 1'b0;
        end
        $display("test_reset_midflight done");
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        test_reset();
        test_write_read();
        test_round_robin();
        test_concurrent();
        test_hazard();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
